// File: rtl/rd_ctrl_param.sv
// rd_ctrl_param: read-side controller for a dual-clock gray-pointer FIFO.
// Extra-MSB pointers give full/empty disambiguation; all flags are registered from next-state values.
module rd_ctrl_param #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr_g,
    input  logic                  rd_req,
    input  logic                  clr_err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr_g,
    output logic                  rd_data_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE = PW'(AE_THRESH);

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wr_ptr_b, rd_ptr_b, rd_ptr_nxt, lvl_nxt;

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        for (int i = 0; i < PW; i++) g2b[i] = ^(g >> i);
    endfunction

    always_ff @(posedge rd_clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wr_ptr_g;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end

    assign wr_ptr_b   = g2b(sync_q[SYNC_STAGES-1]);
    assign rd_en      = rd_req & ~empty;
    assign rd_addr    = rd_ptr_b[ADDR_WIDTH-1:0];
    assign rd_ptr_nxt = rd_ptr_b + PW'(rd_en);
    assign lvl_nxt    = wr_ptr_b - rd_ptr_nxt;

    always_ff @(posedge rd_clk or posedge rst)
        if (rst) begin
            rd_ptr_b     <= '0;
            rd_ptr_g     <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_ptr_b     <= rd_ptr_nxt;
            rd_ptr_g     <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
            empty        <= rd_ptr_nxt == wr_ptr_b;
            almost_empty <= lvl_nxt <= AE;
            rd_level     <= lvl_nxt;
            underflow    <= (rd_req & empty) | (underflow & ~clr_err);
        end

    // Valid pipe is cleared by reset so in-flight read data is dropped.
    generate
        if (RD_LATENCY == 0) begin : g_nolat
            assign rd_data_valid = rd_en;
        end else begin : g_lat
            logic [RD_LATENCY-1:0] vp;
            always_ff @(posedge rd_clk or posedge rst)
                if (rst) vp <= '0;
                else vp <= RD_LATENCY'({vp, rd_en});
            assign rd_data_valid = vp[RD_LATENCY-1];
        end
    endgenerate
endmodule
